lsu_mem_stage: RTL and testbench

- Load/store unit for the multi-cycle LoongArch core; sits directly downstream of the EXE state, between the core FSM and the data SRAM.
- Accepts one memory request per handshake: address from ALU result, store data from rkd, plus an op code.
- Generates SRAM enable, byte write strobes and aligned write data. Aligns and sign- or zero-extends load data.
- Returns one response per request, so the core's MEM state waits on a handshake instead of a fixed cycle.

---
 rtl/lsu_mem_stage.sv | 142 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store unit between the core FSM and the data SRAM: one request in, one response out.
// Optional alignment-error checking is enabled by defining LSU_ALE_CHECK_EN.
module lsu_mem_stage #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_ale,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = RD_LATENCY[2:0];

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        wr_q, unsigned_q, ale_q;
  logic [2:0]  cnt;
  logic        misaligned;
  logic [3:0]  strobe;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

`ifdef LSU_ALE_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = |req_addr[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS:  state_nxt = wr_q ? RESP : WAIT;
      WAIT:    if (cnt == LAT) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers are reset too, so the SRAM-facing outputs read as zero out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      unsigned_q <= 1'b0;
      ale_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          size_q     <= req_size;
          wr_q       <= req_wr;
          unsigned_q <= req_unsigned;
          ale_q      <= misaligned;
          rdata_q    <= '0;
        end
        ACCESS: cnt <= 3'd1;
        WAIT: begin
          if (cnt == LAT) rdata_q <= load_ext;
          else            cnt     <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    strobe          = 4'b1111;
    data_sram_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        strobe          = 4'b0001 << addr_q[1:0];
        data_sram_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strobe          = addr_q[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = data_sram_rdata[8*addr_q[1:0] +: 8];
    half_sel = data_sram_rdata[16*addr_q[1] +: 16];
    load_ext = data_sram_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
      2'b01:   load_ext = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
      default: ;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE);
    resp_valid   = (state == RESP);
    data_sram_en = (state == ACCESS);
    data_sram_we = (state == ACCESS && wr_q) ? strobe : 4'b0000;
  end

  assign data_sram_addr = {addr_q[31:2], 2'b00};
  assign resp_rdata     = rdata_q;
  assign resp_ale       = ale_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a byte-array reference model predicts SRAM accesses
// and responses; independent monitors compare them as the DUT presents them.
module tb_lsu_mem_stage;

  localparam int RD_LAT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        ale;
    int          due;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_ale;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic stall = 1'b0;

  resp_t rq[$];
  acc_t  aq[$];
  logic [7:0] ref_mem [64];

  lsu_mem_stage #(.RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_ale(resp_ale),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] v;
    v = w * 32'h9E3779B1;
    return v ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model: fixed read latency, random data on the bus whenever nothing valid is due.
  logic [31:0] mem [16];
  logic [31:0] pipe_d [RD_LAT];
  logic        pipe_v [RD_LAT];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
    pipe_d[0] <= mem[data_sram_addr[5:2]];
    pipe_v[0] <= data_sram_en && (data_sram_we == 4'b0000);
    if (reset) begin
      for (int w = 0; w < 16; w++) mem[w] <= init_word(w);
      for (int i = 0; i < RD_LAT; i++) pipe_v[i] <= 1'b0;
    end else if (data_sram_en) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_we[i]) mem[data_sram_addr[5:2]][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  assign data_sram_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

  always @(posedge clk) begin
    #1;
    resp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares SRAM accesses and responses against the scoreboard queues.
  logic  seen = 1'b0;
  resp_t me;
  acc_t  ma;

  always @(negedge clk) begin
    if (reset) begin
      rq.delete();
      aq.delete();
      seen = 1'b0;
    end else begin
      if (data_sram_en) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access actual=en=1 expected=en=0 (cycle %0d)", cyc);
        end else begin
          ma = aq.pop_front();
          check("sram_we", {28'd0, data_sram_we}, {28'd0, ma.we});
          check("sram_addr", data_sram_addr, ma.addr);
          if (ma.wr) check("sram_wdata", data_sram_wdata, ma.wdata);
        end
      end else begin
        check("we_idle", {28'd0, data_sram_we}, 32'd0);
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=valid=1 expected=valid=0 (cycle %0d)", cyc);
        end else begin
          me = rq[0];
          if (!seen) begin
            check("resp_latency", cyc, me.due);
            seen = 1'b1;
          end
          check("resp_rdata", resp_rdata, me.rdata);
          check("resp_ale", {31'd0, resp_ale}, {31'd0, me.ale});
          check("req_ready_busy", {31'd0, req_ready}, 32'd0);
          if (resp_ready) begin
            void'(rq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic init_ref();
    logic [31:0] iw;
    for (int w = 0; w < 16; w++) begin
      iw = init_word(w);
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = iw[8*b +: 8];
    end
  endtask

  // Reference model: byte-granular memory, predicts access and response for one request.
  task automatic model(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int t);
    int n, off, base;
    logic [31:0] val;
    logic [7:0] b;
    resp_t r;
    acc_t a;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr[5:0]) & 32'h3C;
    off = (n == 1) ? int'(addr[1:0]) : (n == 2) ? int'(addr[1]) * 2 : 0;
`ifdef LSU_ALE_CHECK_EN
    if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) begin
      r.rdata = '0; r.ale = 1'b1; r.due = t;
      rq.push_back(r);
      return;
    end
`endif
    a.wr = wr; a.addr = addr & 32'hFFFF_FFFC; a.we = '0; a.wdata = '0;
    r.ale = 1'b0;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        b = wd[8*(i % n) +: 8];
        a.wdata[8*i +: 8] = b;
        if (i >= off && i < off + n) begin
          a.we[i] = 1'b1;
          ref_mem[base + i] = b;
        end
      end
      r.rdata = '0;
      r.due = t + 1;
    end else begin
      val = '0;
      for (int k = 0; k < n; k++) val = val | (32'(ref_mem[base + off + k]) << (8 * k));
      if (!uns && n < 4 && ref_mem[base + off + n - 1][7]) val = val | (32'hFFFF_FFFF << (8 * n));
      r.rdata = val;
      r.due = t + 1 + RD_LAT;
    end
    aq.push_back(a);
    rq.push_back(r);
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      req_valid = 1'($urandom_range(0, 1));
      req_wr = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout actual=req_ready=0 expected=req_ready=1");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    model(wr, size, uns, addr, wd, cyc + 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || aq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rq.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0 pending", rq.size() + aq.size());
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    init_ref();
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_ale", {31'd0, resp_ale}, 32'd0);
    check("rst_sram_en", {31'd0, data_sram_en}, 32'd0);
    check("rst_sram_addr", data_sram_addr, 32'd0);
    check("rst_sram_wdata", data_sram_wdata, 32'd0);
    reset = 1'b0;

    issue(1'b1, 2'b10, 1'b0, 32'h1C00_0010, 32'hDEAD_BEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h1C00_0003, 32'h0000_00A5);
    issue(1'b1, 2'b10, 1'b0, 32'h1C00_0004, 32'h12F0_5678);
    issue(1'b0, 2'b00, 1'b0, 32'h1C00_0006, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h1C00_0006, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1C00_0006, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h1C00_0000, 32'h8001_0000);
    issue(1'b1, 2'b01, 1'b0, 32'h1C00_0009, 32'h0000_7E81);
    issue(1'b0, 2'b11, 1'b0, 32'h1C00_0008, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h1C00_0010, 32'h0);
    drain();

    // Response held off for several cycles: outputs must stay put.
    stall = 1'b1;
    issue(1'b0, 2'b01, 1'b0, 32'h1C00_0002, 32'h0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) begin
      @(negedge clk);
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_rdata", resp_rdata, 32'hFFFF_8001);
    end
    stall = 1'b0;
    drain();

    // Reset while waiting for read data, then reset coinciding with an offered store.
    issue(1'b0, 2'b10, 1'b0, 32'h1C00_0020, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("wait_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("wait_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("wait_rst_sram_en", {31'd0, data_sram_en}, 32'd0);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_addr = 32'h1C00_0030; req_wdata = $urandom;
    @(negedge clk);
    check("rst_store_sram_en", {31'd0, data_sram_en}, 32'd0);
    check("rst_store_we", {28'd0, data_sram_we}, 32'd0);
    req_valid = 1'b0;
    init_ref();
    reset = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h1C00_0030, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h1C00_0032, 32'h0000_C3A5);
    issue(1'b0, 2'b01, 1'b1, 32'h1C00_0032, 32'h0);
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom),
            32'h1C00_0000 | 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
